// File: rtl/spi_mem_emu_gen.sv
// SPI mode-0 EEPROM/flash slave emulator bridging the cartridge SPI bus to the RAM arbiter handshake.
// Optional SPI_MEM_EMU_WEL_EN: writes need WEL=1, and WEL clears when CS rises after WRITE/WRSR.
module spi_mem_emu_gen #(
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned MEM_AW     = 20,
    parameter int unsigned PAGE_BITS  = 7,
    parameter logic [23:0] JEDEC_ID   = 24'hFFFFFF
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    inout  wire               spi_miso,
    output logic              mem_begin_wr,
    output logic              mem_begin_rd,
    input  logic              mem_finish,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_data_wr,
    input  logic [7:0]        mem_data_rd
);

    localparam logic [7:0] CMD_WRSR  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_FAST  = 8'h0B;
    localparam logic [7:0] CMD_RDID  = 8'h9F;

    localparam logic [1:0]        ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);
    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((32'd1 << PAGE_BITS) - 32'd1);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_DUMMY, S_RD_DATA, S_WR_DATA, S_RDSR, S_RDID, S_DONE
    } state_e;

    typedef enum logic [1:0] {OP_READ, OP_FAST, OP_WRITE} op_e;

    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    logic [1:0] cs_q;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       mosi_s;
    logic       cs_s;

    logic [2:0] bit_cnt_q;
    logic [6:0] shift_in_q;
    logic [7:0] rx_byte_q;
    logic       byte_strobe_q;

    state_e            state_q;
    op_e               op_q;
    logic [1:0]        abyte_cnt_q;
    logic [15:0]       addr_sh_q;
    logic [23:0]       addr_next;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [7:0]        mem_data_wr_q;
    logic              begin_wr_q;
    logic              begin_rd_q;
    logic              wr_adv_q;
    logic              wel_q;
    logic [1:0]        id_idx_q;
    logic [7:0]        miso_sh_q;
    logic              miso_out_q;
    logic [7:0]        status;
`ifdef SPI_MEM_EMU_WEL_EN
    logic              wr_cmd_q;
`endif

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign mosi_s    = mosi_q[1];
    assign cs_s      = cs_q[1];
    assign addr_next = {addr_sh_q, rx_byte_q};
    assign status    = {6'b0, wel_q, 1'b0};

    assign mem_begin_wr = begin_wr_q;
    assign mem_begin_rd = begin_rd_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_wr  = mem_data_wr_q;
    assign spi_miso     = spi_cs ? 1'bz : miso_out_q;

    // Two-flop synchronisers; spi_clk carries a third flop for edge detection.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            sclk_q <= '0;
            mosi_q <= '0;
            cs_q   <= '1;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            mosi_q <= {mosi_q[0], spi_mosi};
            cs_q   <= {cs_q[0], spi_cs};
        end
    end

    // MSB-first byte receiver; a partial byte is dropped whenever CS is high.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            bit_cnt_q     <= '0;
            shift_in_q    <= '0;
            rx_byte_q     <= '0;
            byte_strobe_q <= 1'b0;
        end else begin
            byte_strobe_q <= 1'b0;
            if (cs_s) begin
                bit_cnt_q <= '0;
            end else if (sclk_rise) begin
                shift_in_q <= {shift_in_q[5:0], mosi_s};
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_q     <= {shift_in_q, mosi_s};
                    byte_strobe_q <= 1'b1;
                end
            end
        end
    end

    // Command FSM, memory handshake and MISO shifter.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q       <= S_CMD;
            op_q          <= OP_READ;
            abyte_cnt_q   <= '0;
            addr_sh_q     <= '0;
            mem_addr_q    <= '0;
            mem_data_wr_q <= '0;
            begin_wr_q    <= 1'b0;
            begin_rd_q    <= 1'b0;
            wr_adv_q      <= 1'b0;
            wel_q         <= 1'b0;
            id_idx_q      <= '0;
            miso_sh_q     <= 8'hFF;
            miso_out_q    <= 1'b1;
`ifdef SPI_MEM_EMU_WEL_EN
            wr_cmd_q      <= 1'b0;
`endif
        end else begin
            begin_wr_q <= 1'b0;
            begin_rd_q <= 1'b0;
            wr_adv_q   <= 1'b0;
            if (cs_s) begin
                state_q    <= S_CMD;
                miso_sh_q  <= 8'hFF;
                miso_out_q <= 1'b1;
`ifdef SPI_MEM_EMU_WEL_EN
                if (wr_cmd_q) begin
                    wel_q <= 1'b0;
                end
                wr_cmd_q <= 1'b0;
`endif
            end else begin
                if (sclk_fall) begin
                    miso_out_q <= miso_sh_q[7];
                    miso_sh_q  <= {miso_sh_q[6:0], 1'b1};
                end
                // Page-wrapped advance, one cycle after the write pulse so the pulse sees the old address.
                if (wr_adv_q) begin
                    mem_addr_q <= (mem_addr_q & ~PAGE_MASK) | ((mem_addr_q + ADDR_ONE) & PAGE_MASK);
                end
                if (byte_strobe_q) begin
                    unique case (state_q)
                        S_CMD: begin
                            abyte_cnt_q <= '0;
                            addr_sh_q   <= '0;
                            miso_sh_q   <= 8'hFF;
                            case (rx_byte_q)
                                CMD_WRSR: begin
                                    state_q <= S_DONE;
`ifdef SPI_MEM_EMU_WEL_EN
                                    wr_cmd_q <= 1'b1;
`endif
                                end
                                CMD_WRITE: begin
                                    state_q <= S_ADDR;
                                    op_q    <= OP_WRITE;
`ifdef SPI_MEM_EMU_WEL_EN
                                    wr_cmd_q <= 1'b1;
`endif
                                end
                                CMD_READ: begin
                                    state_q <= S_ADDR;
                                    op_q    <= OP_READ;
                                end
                                CMD_FAST: begin
                                    state_q <= S_ADDR;
                                    op_q    <= OP_FAST;
                                end
                                CMD_WRDI: begin
                                    state_q <= S_DONE;
                                    wel_q   <= 1'b0;
                                end
                                CMD_WREN: begin
                                    state_q <= S_DONE;
                                    wel_q   <= 1'b1;
                                end
                                CMD_RDSR: begin
                                    state_q   <= S_RDSR;
                                    miso_sh_q <= status;
                                end
                                CMD_RDID: begin
                                    state_q   <= S_RDID;
                                    miso_sh_q <= JEDEC_ID[23:16];
                                    id_idx_q  <= 2'd1;
                                end
                                default: state_q <= S_DONE;
                            endcase
                        end
                        S_ADDR: begin
                            addr_sh_q   <= addr_next[15:0];
                            abyte_cnt_q <= abyte_cnt_q + 2'd1;
                            if (abyte_cnt_q == ADDR_LAST) begin
                                mem_addr_q <= MEM_AW'(addr_next);
                                case (op_q)
                                    OP_WRITE: state_q <= S_WR_DATA;
                                    OP_FAST:  state_q <= S_DUMMY;
                                    default: begin
                                        state_q    <= S_RD_DATA;
                                        begin_rd_q <= 1'b1;
                                    end
                                endcase
                            end
                        end
                        S_DUMMY: begin
                            state_q    <= S_RD_DATA;
                            begin_rd_q <= 1'b1;
                        end
                        S_RD_DATA: begin
                            mem_addr_q <= mem_addr_q + ADDR_ONE;
                            begin_rd_q <= 1'b1;
                            miso_sh_q  <= 8'hFF;
                        end
                        S_WR_DATA: begin
                            mem_data_wr_q <= rx_byte_q;
                            wr_adv_q      <= 1'b1;
`ifdef SPI_MEM_EMU_WEL_EN
                            begin_wr_q    <= wel_q;
`else
                            begin_wr_q    <= 1'b1;
`endif
                        end
                        S_RDSR: miso_sh_q <= status;
                        S_RDID: begin
                            case (id_idx_q)
                                2'd1:    miso_sh_q <= JEDEC_ID[15:8];
                                2'd2:    miso_sh_q <= JEDEC_ID[7:0];
                                default: miso_sh_q <= 8'hFF;
                            endcase
                            id_idx_q <= (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                        end
                        S_DONE: miso_sh_q <= 8'hFF;
                    endcase
                end
                // Read data lands last so it wins over a same-cycle strobe reload.
                if (state_q == S_RD_DATA && mem_finish) begin
                    miso_sh_q <= mem_data_rd;
                end
            end
        end
    end

endmodule
